mips_exec_unit: RTL and testbench

//  Parametrised single-issue execute/write-back unit for the MIPS_CPU datapath.

---
 rtl/mips_exec_unit_if.sv | 22 ++
 rtl/mips_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_mips_exec_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_exec_unit_if.sv
// rtl/mips_exec_unit_if.sv - instruction issue and completion bundle for mips_exec_unit
interface mips_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     Instruction;
  logic            out_valid;
  logic [XLEN-1:0] ALU_Result;
  logic [4:0]      out_rd;
  logic            out_we;

  modport master (
    output in_valid, Instruction,
    input  in_ready, out_valid, ALU_Result, out_rd, out_we
  );

  modport slave (
    input  in_valid, Instruction,
    output in_ready, out_valid, ALU_Result, out_rd, out_we
  );
endinterface

// File: rtl/mips_exec_unit.sv
// rtl/mips_exec_unit.sv - single-issue execute/write-back unit with register file and iterative multiplier
module mips_exec_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int MUL_K = 1
) (
  input  logic            CLK,
  input  logic            RSTn,
  mips_exec_unit_if.slave io,
  input  logic            ld_en,
  input  logic [4:0]      ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      dbg_ra,
  output logic [XLEN-1:0] dbg_rd,
  output logic            busy
);
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int N  = XLEN / MUL_K;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   mrd_q;
  logic            mwe_q;
  logic [XLEN-1:0] alu_q;
  logic [4:0]      out_rd_q;
  logic            out_we_q, out_valid_q;

  logic [1:0]      op;
  logic [RW-1:0]   rs_idx, rt_idx, rd_idx, ld_idx, dbg_idx;
  logic [4:0]      shamt;
  logic            wr_en, accept, mul_last;
  logic [XLEN-1:0] rs_val, rt_val, alu_res, partial;
  logic            wb_en;
  logic [RW-1:0]   wb_idx;
  logic [XLEN-1:0] wb_data;
  logic            unused_bits;

  function automatic logic [XLEN-1:0] rf_read(input logic [RW-1:0] idx);
    return (idx == '0) ? '0 : regs_q[idx];
  endfunction

  assign op      = io.Instruction[27:26];
  assign rs_idx  = io.Instruction[21 +: RW];
  assign rt_idx  = io.Instruction[16 +: RW];
  assign rd_idx  = io.Instruction[11 +: RW];
  assign shamt   = io.Instruction[10:6];
  assign wr_en   = io.Instruction[5];
  assign ld_idx  = ld_addr[RW-1:0];
  assign dbg_idx = dbg_ra[RW-1:0];
  assign unused_bits = ^{io.Instruction, ld_addr, dbg_ra};

  assign rs_val = rf_read(rs_idx);
  assign rt_val = rf_read(rt_idx);
  assign dbg_rd = rf_read(dbg_idx);

  assign io.in_ready   = (state_q == IDLE) && RSTn;
  assign busy          = (state_q == MUL);
  assign accept        = io.in_valid && io.in_ready;
  assign mul_last      = (cnt_q == CW'(1));
  assign io.out_valid  = out_valid_q;
  assign io.ALU_Result = alu_q;
  assign io.out_rd     = out_rd_q;
  assign io.out_we     = out_we_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = rs_val + rt_val;
      OP_SUB: alu_res = rs_val - rt_val;
      OP_MUL: alu_res = '0;
      default: begin
        if (int'(shamt) < XLEN)
          alu_res = io.Instruction[0] ? (rs_val >> shamt) : (rs_val << shamt);
      end
    endcase
  end

  // Shift-add step: retire the low MUL_K multiplier bits against the shifted multiplicand.
  always_comb begin
    partial = '0;
    for (int k = 0; k < MUL_K; k++)
      if (mplier_q[k]) partial = partial + (mcand_q << k);
    acc_d = acc_q + partial;
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_idx  = '0;
    wb_data = '0;
    if (state_q == IDLE && accept && op != OP_MUL) begin
      wb_en   = wr_en && (rd_idx != '0);
      wb_idx  = rd_idx;
      wb_data = alu_res;
    end else if (state_q == MUL && mul_last) begin
      wb_en   = mwe_q;
      wb_idx  = mrd_q;
      wb_data = acc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mrd_q       <= '0;
      mwe_q       <= 1'b0;
      alu_q       <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      // Write-back is applied after the host load so it wins on an index collision.
      if (ld_en && ld_idx != '0) regs_q[ld_idx] <= ld_data;
      if (wb_en) regs_q[wb_idx] <= wb_data;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand_q  <= rs_val;
              mplier_q <= rt_val;
              acc_q    <= '0;
              cnt_q    <= CW'(N);
              mrd_q    <= rd_idx;
              mwe_q    <= wr_en && (rd_idx != '0);
              state_q  <= MUL;
            end else begin
              alu_q       <= alu_res;
              out_rd_q    <= 5'(rd_idx);
              out_we_q    <= wr_en && (rd_idx != '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << MUL_K;
          mplier_q <= mplier_q >> MUL_K;
          cnt_q    <= cnt_q - CW'(1);
          if (mul_last) begin
            alu_q       <= acc_d;
            out_rd_q    <= 5'(mrd_q);
            out_we_q    <= mwe_q;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_exec_unit.sv
// tb/tb_mips_exec_unit.sv - scoreboard bench for mips_exec_unit with a behavioural reference model
module tb_mips_exec_unit;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int MUL_K = 1;
  localparam int NSTEP = XLEN / MUL_K;

  logic            CLK = 1'b0;
  logic            RSTn;
  logic            ld_en;
  logic [4:0]      ld_addr;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      dbg_ra;
  logic [XLEN-1:0] dbg_rd;
  logic            busy;

  always #5 CLK = ~CLK;

  mips_exec_unit_if #(.XLEN(XLEN)) bus ();

  mips_exec_unit #(.XLEN(XLEN), .NREGS(NREGS), .MUL_K(MUL_K)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .io      (bus),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .dbg_ra  (dbg_ra),
    .dbg_rd  (dbg_rd),
    .busy    (busy)
  );

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    logic            we;
  } exp_t;

  exp_t            exp_q[$];
  logic [XLEN-1:0] m_regs [NREGS];
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd,
                                     input int sh, input int funct);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], funct[5:0]};
    return w;
  endfunction

  function automatic logic [XLEN-1:0] ref_alu(input logic [31:0] ins, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int sh;
    sh = int'(ins[10:6]);
    case (ins[27:26])
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: return a * b;
      default: begin
        if (sh >= XLEN) return '0;
        return ins[0] ? (a >> sh) : (a << sh);
      end
    endcase
  endfunction

  task automatic model_exec(input logic [31:0] ins);
    int rs, rt, rd;
    exp_t e;
    rs = int'(ins[25:21]) % NREGS;
    rt = int'(ins[20:16]) % NREGS;
    rd = int'(ins[15:11]) % NREGS;
    e.res = ref_alu(ins, m_regs[rs], m_regs[rt]);
    e.rd  = 5'(rd);
    e.we  = ins[5] && (rd != 0);
    if (e.we) m_regs[rd] = e.res;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RSTn === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("alu_result", {32'd0, bus.ALU_Result}, {32'd0, e.res});
        chk("out_rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
        chk("out_we", {63'd0, bus.out_we}, {63'd0, e.we});
      end
    end
  end

  task automatic issue(input logic [31:0] ins, output int stall);
    bus.in_valid    = 1'b1;
    bus.Instruction = ins;
    stall = 0;
    @(negedge CLK);
    while (bus.in_ready !== 1'b1 && stall < 200) begin
      stall++;
      @(negedge CLK);
    end
    if (bus.in_ready !== 1'b1) begin
      chk("issue_timeout", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      model_exec(ins);
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 200) begin
      t++;
      @(negedge CLK);
    end
    if (busy !== 1'b0) chk("idle_timeout", {63'd0, busy}, 64'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input int idx, input logic [XLEN-1:0] data);
    ld_en   = 1'b1;
    ld_addr = idx[4:0];
    ld_data = data;
    @(posedge CLK);
    #1;
    ld_en = 1'b0;
    if (idx % NREGS != 0) m_regs[idx % NREGS] = data;
  endtask

  task automatic chk_reg(input int idx, input logic [XLEN-1:0] exp);
    dbg_ra = idx[4:0];
    #1;
    chk($sformatf("dbg_r%0d", idx), {32'd0, dbg_rd}, {32'd0, exp});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    int st;
    logic [31:0] ins;
    RSTn = 1'b0;
    bus.in_valid = 1'b0;
    bus.Instruction = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    dbg_ra = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;

    // T1 reset
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    RSTn = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int i = 0; i < NREGS; i++) chk_reg(i, '0);
    @(posedge CLK);
    #1;

    // T2 ADD with write-back
    do_load(1, 7);
    do_load(2, 5);
    issue(mk(0, 1, 2, 3, 0, 'h20), st);
    chk_reg(3, 12);

    // T3 SUB without write-back
    issue(mk(1, 1, 2, 3, 0, 'h00), st);
    chk_reg(3, 12);

    // T4 MUL stalls a held instruction
    do_load(1, 32'hFFFF_FFFF);
    do_load(2, 3);
    issue(mk(2, 1, 2, 6, 0, 'h20), st);
    chk("mul_busy", {63'd0, busy}, 64'd1);
    issue(mk(0, 6, 2, 7, 0, 'h20), st);
    chk("mul_stall_cycles", 64'(st), 64'(NSTEP));
    chk_reg(6, 32'hFFFF_FFFD);
    chk_reg(7, 32'h0000_0000);

    // T5 back-to-back dependency, then write to r0
    do_load(1, 7);
    do_load(2, 5);
    issue(mk(0, 1, 2, 4, 0, 'h20), st);
    issue(mk(3, 4, 0, 5, 4, 'h20), st);
    chk("b2b_stall_cycles", 64'(st), 64'd0);
    chk_reg(5, 192);
    issue(mk(0, 1, 2, 0, 0, 'h20), st);
    chk_reg(0, 0);

    // T7 host load and write-back to the same index at one edge
    ld_en   = 1'b1;
    ld_addr = 5'd3;
    ld_data = 32'hDEAD_BEEF;
    m_regs[3] = 32'hDEAD_BEEF;
    issue(mk(0, 1, 2, 3, 0, 'h20), st);
    ld_en = 1'b0;
    chk_reg(3, 12);

    // Randomised traffic over a small register window to force dependencies
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        do_load(int'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 0) ? XLEN'($urandom_range(0, 20)) : XLEN'($urandom));
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge CLK);
          #1;
        end
        ins = $urandom;
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        issue(ins, st);
      end
    end
    wait_idle();
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < NREGS; i++) chk_reg(i, m_regs[i]);
    @(posedge CLK);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // T6 reset during MUL drops the result
    do_load(1, 9);
    do_load(2, 4);
    issue(mk(2, 1, 2, 6, 0, 'h20), st);
    repeat (9) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    @(posedge CLK);
    #1;
    chk("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t6_in_ready_rst", {63'd0, bus.in_ready}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    RSTn = 1'b1;
    for (int c = 0; c < NSTEP + 4; c++) begin
      @(negedge CLK);
      chk("t6_no_completion", {63'd0, bus.out_valid}, 64'd0);
    end
    chk("t6_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int i = 0; i < NREGS; i++) chk_reg(i, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
